calc_bin2bcd: RTL
=================

// Module: calc_bin2bcd
// PURPOSE
//  Downstream display stage for the calculator datapath: takes a binary result ({cout,prod} of
//  multiplier_8, or {rem,quo}-style packed operands, one field per request) and converts it to
//  packed BCD by sequential shift-and-add-3 (double dabble), one input bit per clock. Valid/ready
//  on both sides; one conversion in flight. Feeds the 7-segment/digit driver.
// PARAMETERS
//  WIDTH   16  binary input width in bits (>=1)
//  DIGITS  5   BCD output digits; must satisfy 10**DIGITS > 2**WIDTH-1 (16->5, 8->3)
// PORTS
//  clk        in   1           single clock, all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           in_data holds a value to convert
//  in_ready   out  1           block can accept; =1 only in IDLE
//  in_data    in   WIDTH       unsigned binary value
//  out_valid  out  1           out_bcd holds a completed result
//  out_ready  in   1           consumer takes result
//  out_bcd    out  4*DIGITS    packed BCD, digit 0 (units) in [3:0], digit k in [4k+3:4k]
//  busy       out  1           =1 in SHIFT or DONE
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, out_valid=0, out_bcd=0, bit counter=0, shift regs=0.
//   in_ready/busy are decoded from state: in_ready=1, busy=0 from the first cycle after reset.
//  States:
//   IDLE : in_ready=1. in_valid=1 at edge -> latch in_data into bin shift reg, clear BCD shift
//          reg, counter=WIDTH, -> SHIFT. in_valid=0 -> stay.
//   SHIFT: in_ready=0. Each edge: every BCD digit >=5 gets +3 (4-bit, no carry out), then
//          {bcd,bin} shifted left 1 (bin MSB enters bcd bit 0); counter-1. On the edge where
//          counter goes 1->0: copy final BCD to out_bcd, out_valid<=1, -> DONE.
//   DONE : out_valid=1, out_bcd stable. out_ready=1 at edge -> out_valid<=0, -> IDLE.
//          out_ready=0 -> hold indefinitely, no input accepted.
//  Latency: input accepted at edge E -> out_valid=1 visible after edge E+WIDTH (16 cycles default).
//  Throughput: min WIDTH+2 cycles per conversion (accept, WIDTH shifts, handoff); no overlap.
//  out_bcd holds the last completed result through IDLE/SHIFT of the next conversion; it changes
//   only on the SHIFT->DONE edge (or reset). Intermediate BCD never appears on out_bcd.
//  in_valid while not IDLE: ignored, in_data not sampled (producer must hold until in_ready=1).
//  out_ready while not DONE: ignored.
//  Digit correction uses the pre-shift value of each digit; corrections of all digits in one
//   cycle are independent (no inter-digit carry); any digit reaching >9 after shift is a bug.
//  Reset mid-conversion (SHIFT or DONE): conversion discarded, out_valid=0, out_bcd=0, -> IDLE.
//  rst and in_valid same edge: reset wins, nothing accepted.
//  in_data=0: normal WIDTH-cycle conversion, result all-zero digits (no shortcut).
// TESTING
//  1 in_data=16'd0, out_ready=1 -> out_valid after exactly 16 cycles, out_bcd=20'h00000.
//  2 in_data=16'd65535 -> out_bcd=20'h65535; in_data=16'd12345 -> 20'h12345;
//    in_data=16'd255 ({cout=0,prod=255}) -> 20'h00255.
//  3 Backpressure: result 20'h00042 with out_ready=0 for 10 cycles -> out_valid/out_bcd stable,
//    in_ready=0; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
//  4 in_valid pulsed with 16'd999 during SHIFT of 16'd7 -> ignored; out_bcd=20'h00007 only.
//  5 rst=1 at cycle 8 of conversion of 16'd500 -> out_valid never rises, out_bcd=0, in_ready=1
//    next cycle; new request 16'd500 then yields 20'h00500.
//  6 Random: 1000 values back-to-back (in_valid held, out_ready random) -> each out_bcd equals
//    reference decimal conversion, order preserved, no drops or duplicates.

Source files
------------

// File: rtl/calc_bin2bcd.sv
`default_nettype none
// ============================================================================
//  Module      : calc_bin2bcd
//  Description : Sequential binary-to-packed-BCD converter (double dabble).
//                Converts one input bit per clock, with valid/ready handshakes
//                on both sides and one conversion in flight at a time.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_bin2bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int C_BCD_W = 4 * DIGITS;
  localparam int C_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     bin_q;
  logic [WIDTH-1:0]     bin_d;
  logic [C_BCD_W-1:0]   bcd_q;
  logic [C_BCD_W-1:0]   bcd_d;
  logic [C_BCD_W-1:0]   bcd_adj;
  logic [C_CNT_W-1:0]   cnt_q;
  logic                 out_valid_q;
  logic [C_BCD_W-1:0]   out_bcd_q;
  logic                 last_shift;

  // Add-3 correction per digit, based only on that digit's pre-shift value.
  // Digits are corrected independently: no carry crosses a digit boundary.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign bcd_adj[4*g +: 4] = (bcd_q[4*g +: 4] >= 4'd5) ? (bcd_q[4*g +: 4] + 4'd3)
                                                         : bcd_q[4*g +: 4];
  end

  // Shift {bcd,bin} left by one; the binary MSB enters BCD bit 0.
  always_comb begin
    bcd_d = {bcd_adj[C_BCD_W-2:0], bin_q[WIDTH-1]};
    bin_d = bin_q << 1;
  end

  assign last_shift = (cnt_q == C_CNT_W'(1));

  // Control FSM with shift registers and registered result/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            bin_q   <= in_data;
            bcd_q   <= '0;
            cnt_q   <= C_CNT_W'(WIDTH);
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bin_q <= bin_d;
          bcd_q <= bcd_d;
          cnt_q <= cnt_q - C_CNT_W'(1);
          if (last_shift) begin
            // Only the finished value ever reaches the output register.
            out_bcd_q   <= bcd_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;

endmodule
`default_nettype wire
